// File: rtl/comp_zero_pad.sv
// rtl/comp_zero_pad.sv - forwards compressed beats and appends zero beats up to a fixed block size
module comp_zero_pad #(
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pad_en,
  input  logic [CNT_W-1:0]  comp_size,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_eop,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_eop,
  input  logic              m_ready,
  output logic              pad_busy,
  output logic              err_overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  logic [1:0]       state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] remain;
  logic             pad_mode;

  logic             in_fwd;
  logic [CNT_W-1:0] cur_target;
  logic             cur_mode;
  logic [CNT_W:0]   n_raw;
  logic [CNT_W-1:0] n_sat;
  logic             block_full;
  logic             s_fire;
  logic             m_fire;

  // In IDLE the packet parameters come straight from the inputs so the first beat needs no wait.
  always_comb begin
    in_fwd     = (state != ST_PAD);
    cur_target = target;
    cur_mode   = pad_mode;
    n_raw      = {1'b0, beat_cnt} + (CNT_W+1)'(1);
    if (state == ST_IDLE) begin
      cur_target = (comp_size == '0) ? MAX_CNT : comp_size;
      cur_mode   = pad_en;
      n_raw      = (CNT_W+1)'(1);
    end
    n_sat      = (n_raw > {1'b0, MAX_CNT}) ? MAX_CNT : n_raw[CNT_W-1:0];
    block_full = !cur_mode || (n_raw >= {1'b0, cur_target});
  end

  always_comb begin
    s_ready  = in_fwd ? m_ready : 1'b0;
    m_valid  = in_fwd ? s_valid : 1'b1;
    m_data   = in_fwd ? s_data : '0;
    m_eop    = in_fwd ? (s_valid && s_eop && block_full) : (remain == CNT_W'(1));
    pad_busy = (state == ST_PAD);
    s_fire   = s_valid && s_ready;
    m_fire   = m_valid && m_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      target       <= '0;
      remain       <= '0;
      pad_mode     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_overflow <= 1'b0;
      case (state)
        ST_IDLE, ST_PASS: begin
          if (s_fire) begin
            if (state == ST_IDLE) begin
              target   <= cur_target;
              pad_mode <= pad_en;
            end
            // n_raw keeps one extra bit so a beat past a full-size block still flags overflow.
            err_overflow <= cur_mode && (n_raw > {1'b0, cur_target});
            if (s_eop) begin
              beat_cnt <= '0;
              if (block_full) begin
                state <= ST_IDLE;
              end else begin
                remain <= cur_target - n_raw[CNT_W-1:0];
                state  <= ST_PAD;
              end
            end else begin
              beat_cnt <= n_sat;
              state    <= ST_PASS;
            end
          end
        end
        ST_PAD: begin
          if (m_fire) begin
            remain <= remain - CNT_W'(1);
            if (remain == CNT_W'(1)) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
